// File: rtl/out_port_arb_pkg.sv
// Shared definitions for the per-output-port wormhole allocator: port count
// macros, FSM state encodings and small index helpers.
`ifndef OUT_PORT_ARB_DEFINES
`define OUT_PORT_ARB_DEFINES
`define PORT      4
`define PORT_P1   5
`define OARB_IDLE 1'b0
`define OARB_LOCK 1'b1
`endif

package out_port_arb_pkg;

    localparam int NPORT = `PORT_P1;
    localparam int DW    = 2 * NPORT;

    typedef enum logic {
        ST_IDLE = `OARB_IDLE,
        ST_LOCK = `OARB_LOCK
    } oarb_state_e;

    function automatic logic [2:0] onehot_to_idx(input logic [`PORT:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NPORT; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx >= 3'(NPORT - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/out_port_arb_rr_pick.sv
// Combinational round-robin picker: double-width masked priority encoder
// that returns the first requester at or above ptr, wrapping to 0.
module out_port_arb_rr_pick
    import out_port_arb_pkg::*;
(
    input  logic [`PORT:0] req,
    input  logic [2:0]     ptr,
    output logic [`PORT:0] gnt,
    output logic           valid
);

    logic [DW-1:0] dbl_s;
    logic [DW-1:0] below_s;
    logic [DW-1:0] masked_s;
    logic [DW-1:0] iso_s;

    // Upper copy always survives the mask, so the lowest surviving bit is the wrap-aware winner.
    always_comb begin
        dbl_s    = {req, req};
        below_s  = (DW'(1) << ptr) - DW'(1);
        masked_s = dbl_s & ~below_s;
        iso_s    = masked_s & (~masked_s + DW'(1));
        gnt      = iso_s[NPORT-1:0] | iso_s[DW-1:NPORT];
        valid    = |req;
    end

endmodule

// File: rtl/out_port_arb.sv
// Per-output-port wormhole allocator: round-robin grant held head-to-tail,
// credit-gated pops. Optional macro OUT_PORT_ARB_BYPASS_EN re-arbitrates on tail pop.
module out_port_arb
    import out_port_arb_pkg::*;
#(
    parameter int NREQ = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [`PORT:0] req,
    input  logic [`PORT:0] tail,
    input  logic           credit_ok,
    output logic [`PORT:0] sel,
    output logic [`PORT:0] pop,
    output logic           busy
);

    if (NREQ != `PORT_P1) begin : g_nreq_check
        $error("out_port_arb: NREQ must equal PORT+1");
    end

    oarb_state_e    state_r, state_s;
    logic [`PORT:0] sel_r, sel_s;
    logic           busy_r, busy_s;
    logic [2:0]     rr_ptr_r, rr_ptr_s;
    logic [`PORT:0] pick_req_s;
    logic [`PORT:0] pick_gnt_s;
    logic           pick_valid_s;
    logic           tail_pop_s;

`ifdef OUT_PORT_ARB_BYPASS_EN
    logic [`PORT:0] others_s;
    assign others_s   = req & ~sel_r;
    // The releasing owner competes only when nobody else is asking.
    assign pick_req_s = (state_r == ST_LOCK) ? ((others_s != {NREQ{1'b0}}) ? others_s : req) : req;
`else
    assign pick_req_s = req;
`endif

    out_port_arb_rr_pick u_rr_pick (
        .req   (pick_req_s),
        .ptr   (rr_ptr_r),
        .gnt   (pick_gnt_s),
        .valid (pick_valid_s)
    );

    assign pop        = sel_r & req & {NREQ{credit_ok}};
    assign tail_pop_s = |(pop & tail);
    assign sel        = sel_r;
    assign busy       = busy_r;

    // Arbitration and ownership next-state logic.
    always_comb begin
        state_s  = state_r;
        sel_s    = sel_r;
        busy_s   = busy_r;
        rr_ptr_s = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s  = ST_LOCK;
                    sel_s    = pick_gnt_s;
                    busy_s   = 1'b1;
                    rr_ptr_s = next_ptr(onehot_to_idx(pick_gnt_s));
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (tail_pop_s) begin
`ifdef OUT_PORT_ARB_BYPASS_EN
                    if (pick_valid_s) begin
                        state_s  = ST_LOCK;
                        sel_s    = pick_gnt_s;
                        busy_s   = 1'b1;
                        rr_ptr_s = next_ptr(onehot_to_idx(pick_gnt_s));
                    end else begin
                        state_s  = ST_IDLE;
                        sel_s    = {NREQ{1'b0}};
                        busy_s   = 1'b0;
                    end
`else
                    state_s  = ST_IDLE;
                    sel_s    = {NREQ{1'b0}};
                    busy_s   = 1'b0;
`endif
                end else begin
                    state_s  = ST_LOCK;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                sel_s    = {NREQ{1'b0}};
                busy_s   = 1'b0;
                rr_ptr_s = 3'd0;
            end
        endcase
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sel_r    <= {NREQ{1'b0}};
            busy_r   <= 1'b0;
            rr_ptr_r <= 3'd0;
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_s;
            busy_r   <= busy_s;
            rr_ptr_r <= rr_ptr_s;
        end
    end

endmodule
